// File: rtl/y_serial_adder_if.sv
// Bus bundle for the bit-serial adder: operand/start request side and
// result/status side, plus the FSM state for observation.
//
// Handshake: a request is accepted on a rising clk edge where both start
// and ready are 1; a, b and cin are captured on that same edge. ready is
// low for the whole operation. done pulses for exactly one cycle when z,
// cout and v first show the new result, and ready returns on the next
// cycle. There is no back-pressure on the result side.
interface y_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic             v;
  logic [1:0]       state;

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, z, cout, v, state
  );

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, z, cout, v, state
  );
endinterface

// File: rtl/y_serial_adder.sv
// Bit-serial ripple adder: one full-adder bit per clock, LSB first.
// Operands are copied into private shift registers on the accepting edge,
// so they may change freely afterwards. Partial sums accumulate in a
// working register; z/cout/v are only updated on the final RUN cycle.
module y_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  y_serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;

  logic             sum_bit;
  logic             carry_nxt;

  // One full-adder slice on the current operand LSBs and the carry register.
  always_comb begin
    sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  end

  // Next-state and datapath control for IDLE -> RUN (WIDTH cycles) -> DONE.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    cout_d  = cout_q;
    v_d     = v_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = carry_nxt;
        acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the top bit, so v compares it
          // against the carry out of the top bit.
          z_d     = {sum_bit, acc_q[WIDTH-1:1]};
          cout_d  = carry_nxt;
          v_d     = carry_q ^ carry_nxt;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

  // Status decodes straight from the state register.
  always_comb begin
    bus.ready = (state_q == IDLE);
    bus.busy  = (state_q == RUN);
    bus.done  = (state_q == DONE);
    bus.z     = z_q;
    bus.cout  = cout_q;
    bus.v     = v_q;
    bus.state = state_q;
  end

endmodule

// File: tb/tb_y_serial_adder.sv
// Directed bench for y_serial_adder: a WIDTH=32 instance driven from a
// vector table plus hand-written corner sequences, and a WIDTH=4 instance
// swept over every operand combination.
module tb_y_serial_adder;

  logic clk;
  logic reset;

  int checks;
  int errors;

  y_serial_adder_if #(.WIDTH(32)) bus32 ();
  y_serial_adder_if #(.WIDTH(4))  bus4 ();

  y_serial_adder #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave)
  );

  y_serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready32();
    for (int i = 0; i < 100; i++) begin
      if (bus32.ready === 1'b1) break;
      @(posedge clk); #1;
    end
    chk("ready32_wait", {63'd0, bus32.ready}, 64'd1);
  endtask

  // Runs one 32-bit addition. Latency counts the accepting edge as edge 1.
  // Operands are scrambled right after acceptance; z is checked mid-RUN to
  // still show the previous result.
  task automatic run32(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                       input logic [31:0] prev_z,
                       output logic [31:0] oz, output logic oc, output logic ov,
                       output int lat, output int nd);
    wait_ready32();
    bus32.start = 1'b1;
    bus32.a     = ta;
    bus32.b     = tb_v;
    bus32.cin   = tc;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    bus32.a     = $urandom;
    bus32.b     = $urandom;
    bus32.cin   = 1'($urandom_range(0, 1));
    lat = 0;
    nd  = 0;
    oz  = '0;
    oc  = 1'b0;
    ov  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 5) chk("z_hold_in_run", {32'd0, bus32.z}, {32'd0, prev_z});
      if (bus32.done === 1'b1) begin
        nd++;
        if (lat == 0) begin
          lat = k + 1;
          oz  = bus32.z;
          oc  = bus32.cout;
          ov  = bus32.v;
        end
      end
      if (bus32.ready === 1'b1) break;
    end
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc,
                      output logic [3:0] oz, output logic oc, output logic ov, output int nd);
    for (int i = 0; i < 20; i++) begin
      if (bus4.ready === 1'b1) break;
      @(posedge clk); #1;
    end
    bus4.start = 1'b1;
    bus4.a     = ta;
    bus4.b     = tb_v;
    bus4.cin   = tc;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    nd = 0;
    oz = '0;
    oc = 1'b0;
    ov = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bus4.done === 1'b1) begin
        nd++;
        oz = bus4.z;
        oc = bus4.cout;
        ov = bus4.v;
      end
      if (bus4.ready === 1'b1) break;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_z;
    logic        exp_cout;
    logic        exp_v;
  } vec_t;

  vec_t vecs[7];

  logic [31:0] exp_q[$];

  initial begin
    logic [31:0] rz;
    logic        rc, rv;
    logic [31:0] last_z;
    int          lat, nd;
    logic [3:0]  z4;
    logic        c4, v4;
    logic [4:0]  s5;
    logic        ev;

    checks = 0;
    errors = 0;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};

    reset       = 1'b0;
    bus32.start = 1'b0;
    bus32.a     = '0;
    bus32.b     = '0;
    bus32.cin   = 1'b0;
    bus4.start  = 1'b0;
    bus4.a      = '0;
    bus4.b      = '0;
    bus4.cin    = 1'b0;

    // Reset before any clock edge: outputs must settle without a clock.
    // A start is also presented on the first edge while reset is high.
    #2;
    reset       = 1'b1;
    bus32.start = 1'b1;
    bus32.a     = 32'h0000_0005;
    bus32.b     = 32'h0000_0003;
    #1;
    chk("rst_ready", {63'd0, bus32.ready}, 64'd1);
    chk("rst_busy",  {63'd0, bus32.busy},  64'd0);
    chk("rst_done",  {63'd0, bus32.done},  64'd0);
    chk("rst_z",     {32'd0, bus32.z},     64'd0);
    chk("rst_cout",  {63'd0, bus32.cout},  64'd0);
    chk("rst_v",     {63'd0, bus32.v},     64'd0);
    @(posedge clk); #1;
    chk("start_in_reset_ignored", {63'd0, bus32.busy}, 64'd0);
    bus32.start = 1'b0;
    reset       = 1'b0;
    @(posedge clk); #1;

    // Table-driven WIDTH=32 vectors.
    last_z = 32'h0;
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp_z);
    for (int i = 0; i < 7; i++) begin
      run32(vecs[i].a, vecs[i].b, vecs[i].cin, last_z, rz, rc, rv, lat, nd);
      chk($sformatf("v%0d_z", i),       {32'd0, rz},      {32'd0, exp_q.pop_front()});
      chk($sformatf("v%0d_cout", i),    {63'd0, rc},      {63'd0, vecs[i].exp_cout});
      chk($sformatf("v%0d_v", i),       {63'd0, rv},      {63'd0, vecs[i].exp_v});
      chk($sformatf("v%0d_latency", i), 64'(lat),         64'd33);
      chk($sformatf("v%0d_ndone", i),   64'(nd),          64'd1);
      last_z = vecs[i].exp_z;
    end

    // Idle hold: result stays put while start is low.
    repeat (5) @(posedge clk);
    #1;
    chk("idle_hold_z",    {32'd0, bus32.z},    {32'd0, last_z});
    chk("idle_hold_cout", {63'd0, bus32.cout}, 64'd0);
    chk("idle_hold_v",    {63'd0, bus32.v},    64'd1);
    chk("idle_ready",     {63'd0, bus32.ready}, 64'd1);

    // Start held high, operands changed mid-RUN: single done with 1+1, then
    // the next op is only accepted once the FSM is back in IDLE.
    bus32.start = 1'b1;
    bus32.a     = 32'h0000_0001;
    bus32.b     = 32'h0000_0001;
    bus32.cin   = 1'b0;
    @(posedge clk); #1;
    chk("hold_start_busy", {63'd0, bus32.busy}, 64'd1);
    bus32.a = 32'h1234_5678;
    bus32.b = 32'h1234_5678;
    nd = 0;
    rz = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus32.done === 1'b1) begin
        nd++;
        rz = bus32.z;
      end
      if (bus32.ready === 1'b1) break;
    end
    chk("hold_start_ndone", 64'(nd), 64'd1);
    chk("hold_start_z",     {32'd0, rz}, 64'h0000_0002);
    chk("hold_start_idle_after_done", {63'd0, bus32.ready}, 64'd1);
    @(posedge clk); #1;
    chk("hold_start_second_accept", {63'd0, bus32.busy}, 64'd1);
    bus32.start = 1'b0;
    nd = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus32.done === 1'b1) begin
        nd++;
        rz = bus32.z;
      end
      if (bus32.ready === 1'b1) break;
    end
    chk("second_op_ndone", 64'(nd), 64'd1);
    chk("second_op_z",     {32'd0, rz}, 64'h2468_ACF0);

    // Reset at RUN cycle 10: asynchronous clear, no done, clean restart.
    bus32.start = 1'b1;
    bus32.a     = 32'h0000_FFFF;
    bus32.b     = 32'h0000_0001;
    bus32.cin   = 1'b0;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    chk("pre_reset_busy", {63'd0, bus32.busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_z",     {32'd0, bus32.z},     64'd0);
    chk("mid_rst_cout",  {63'd0, bus32.cout},  64'd0);
    chk("mid_rst_v",     {63'd0, bus32.v},     64'd0);
    chk("mid_rst_busy",  {63'd0, bus32.busy},  64'd0);
    chk("mid_rst_ready", {63'd0, bus32.ready}, 64'd1);
    #2;
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus32.done === 1'b1) nd++;
    end
    chk("post_rst_no_done", 64'(nd), 64'd0);
    run32(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0, rz, rc, rv, lat, nd);
    chk("post_rst_z",     {32'd0, rz}, 64'h0000_0030);
    chk("post_rst_ndone", 64'(nd),     64'd1);

    // Exhaustive WIDTH=4 sweep against a 5-bit reference sum.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          s5 = 5'(ia) + 5'(ib) + 5'(ic);
          ev = (ia[3] == ib[3]) && (s5[3] != ia[3]);
          run4(4'(ia), 4'(ib), 1'(ic), z4, c4, v4, nd);
          chk($sformatf("w4_%0d_%0d_%0d", ia, ib, ic),
              {56'd0, nd == 1, ev, c4 == 1'b0 ? 1'b0 : 1'b1, z4, v4},
              {56'd0, 1'b1, v4, s5[4], s5[3:0], ev});
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
